// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer feeding simple_cpu.
// Holds the default widths, the NOP encoding and the fetch state enum.
// Combinational only: no latency, no backpressure.
package cpu_pkg;

    localparam int INSTR_WIDTH_DEF = 20;
    localparam int PC_BITS_DEF     = 5;

    // The CPU treats an all-zero word as a no-operation.
    localparam logic [INSTR_WIDTH_DEF-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_rom.sv
// Program memory: 2^ADDR_BITS words, one synchronous write port, one registered read port.
// Read data appears one clock after the address is presented.
// No backpressure; contents are intentionally not reset.
module instr_rom #(
    parameter int WIDTH     = 20,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 wen_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [WIDTH-1:0] rdata_q;

    // Write and registered read; a read of the address being written returns the old word.
    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer: steps a program counter through a loadable program memory.
// First word valid two edges after start; each word held ISSUE_CYCLES clocks plus stall cycles.
// stall freezes the current issue; stop aborts to IDLE and wins over start and stall.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter int PC_BITS      = PC_BITS_DEF,
    parameter int ISSUE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic [PC_BITS:0]       prog_len,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int                 CNT_W       = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_RELOAD = CNT_W'(ISSUE_CYCLES - 1);
    localparam logic [PC_BITS:0]   MAX_LEN     = (PC_BITS + 1)'(2 ** PC_BITS);

    fetch_state_e           state_q;
    logic [PC_BITS-1:0]     pc_q;
    logic [PC_BITS:0]       len_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   valid_q;
    logic                   done_q;

    logic [INSTR_WIDTH-1:0] rom_rdata;
    logic [PC_BITS-1:0]     rd_addr;
    logic [PC_BITS:0]       pc_inc;
    logic [PC_BITS:0]       len_clamped;
    logic                   start_ok;
    logic                   last_hold;
    logic                   more_words;
    logic                   rom_wen;

    // The end-of-program compare is one bit wider than pc so a full-size program runs every word.
    assign pc_inc      = {1'b0, pc_q} + 1'b1;
    assign more_words  = (pc_inc < len_q);
    assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign start_ok    = start && !stop && (prog_len != '0);
    assign last_hold   = (state_q == ISSUE) && !stop && !stall && (cnt_q == '0);
    assign rom_wen     = prog_wen && ((state_q == IDLE) || (state_q == DONE));

    // Present the next word's address during the last hold cycle so it lands with no bubble;
    // otherwise keep re-reading the current pc so the registered read data stays put.
    always_comb begin
        rd_addr = pc_q;
        if (last_hold) begin
            rd_addr = more_words ? pc_inc[PC_BITS-1:0] : '0;
        end
    end

    instr_rom #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PC_BITS)
    ) u_rom (
        .clk     (clk),
        .wen_i   (rom_wen),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr),
        .rdata_o (rom_rdata)
    );

    // Sequencer FSM: start/stop handling, hold counting, pc advance and end-of-program decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                        len_q   <= len_clamped;
                        done_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state_q <= IDLE;
                        pc_q    <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                        cnt_q   <= HOLD_RELOAD;
                    end
                end
                ISSUE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        pc_q    <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (stall) begin
                        cnt_q <= cnt_q;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (more_words) begin
                        pc_q  <= pc_inc[PC_BITS-1:0];
                        cnt_q <= HOLD_RELOAD;
                    end else if (loop_en) begin
                        pc_q  <= '0;
                        cnt_q <= HOLD_RELOAD;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                    end else if (start_ok) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                        len_q   <= len_clamped;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The memory's read register is the instruction register; gate it to NOP whenever nothing is live.
    assign instruction = valid_q ? rom_rdata : INSTR_WIDTH'(NOP_WORD);
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == FETCH) || (state_q == ISSUE);
    assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, a per-cycle reference model and literal spot checks.
module tb_instr_fetch;

    localparam int IW  = 20;
    localparam int PB  = 5;
    localparam int ISC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_wen = 1'b0;
    logic [PB-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [PB:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          stall = 1'b0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .INSTR_WIDTH  (IW),
        .PC_BITS      (PB),
        .ISSUE_CYCLES (ISC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_wen    (prog_wen),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .stall       (stall),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: the program is "starting" for one cycle after an accepted start,
    // then shows word m_pc for a number of unstalled cycles before moving on.
    logic [IW-1:0] m_mem [32];
    bit            m_starting, m_valid, m_done;
    int            m_pc, m_len, m_shown;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_starting = 0; m_valid = 0; m_done = 0;
            m_pc = 0; m_len = 0; m_shown = 0;
        end else begin
            if (prog_wen && !(m_starting || m_valid)) m_mem[prog_addr] = prog_data;
            if (stop) begin
                if (m_starting || m_valid || m_done) begin
                    m_starting = 0; m_valid = 0; m_done = 0; m_pc = 0;
                end
            end else if (!(m_starting || m_valid) && start && prog_len != 0) begin
                m_starting = 1; m_done = 0; m_pc = 0;
                m_len = (int'(prog_len) > 32) ? 32 : int'(prog_len);
            end else if (m_starting) begin
                m_starting = 0; m_valid = 1; m_shown = 1;
            end else if (m_valid && !stall) begin
                if (m_shown < ISC) begin
                    m_shown++;
                end else begin
                    m_shown = 1;
                    if (m_pc + 1 < m_len) m_pc = m_pc + 1;
                    else if (loop_en) m_pc = 0;
                    else begin m_valid = 0; m_done = 1; end
                end
            end
        end
    end

    // Every cycle outside reset, the DUT outputs must agree with the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", 32'(instr_valid), 32'(m_valid));
            chk("model_instr", 32'(instruction), m_valid ? 32'(m_mem[m_pc[PB-1:0]]) : 32'h0);
            chk("model_busy", 32'(busy), 32'(m_starting || m_valid));
            chk("model_done", 32'(done), 32'(m_done));
            if (m_valid) chk("model_pc", 32'(pc), 32'(m_pc));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int a, input logic [IW-1:0] d);
        prog_wen = 1'b1; prog_addr = PB'(a); prog_data = d;
        @(negedge clk);
        prog_wen = 1'b0;
    endtask

    // Pulse start; returns at the negedge of the first valid cycle.
    task automatic run(input logic [PB:0] len);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int max, output int last_pc, output int nvalid);
        int n = 0;
        last_pc = -1; nvalid = 0;
        while (!done && n < max) begin
            if (instr_valid) begin last_pc = int'(pc); nvalid++; end
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done), 32'h1);
    endtask

    logic [IW-1:0] prog3 [3];
    int lp, nv;

    initial begin
        prog3[0] = 20'h1A001; prog3[1] = 20'h2B002; prog3[2] = 20'h3C003;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) load(i, prog3[i]);
        for (int i = 3; i < 32; i++) load(i, IW'(20'h50000 + i));

        // Single pass: each word for exactly 3 clocks, no gaps.
        loop_en = 1'b0;
        run(6'd3);
        for (int i = 0; i < 9; i++) begin
            chk("pass_instr", 32'(instruction), 32'(prog3[i / 3]));
            chk("pass_pc", 32'(pc), 32'(i / 3));
            @(negedge clk);
        end
        chk("pass_end_valid", 32'(instr_valid), 32'h0);
        chk("pass_end_instr", 32'(instruction), 32'h0);
        chk("pass_end_done", 32'(done), 32'h1);

        // Looped run, then drop loop_en and finish on pc 2.
        loop_en = 1'b1;
        run(6'd3);
        for (int i = 0; i < 12; i++) begin
            chk("loop_instr", 32'(instruction), 32'(prog3[(i / 3) % 3]));
            @(negedge clk);
        end
        chk("loop_done_low", 32'(done), 32'h0);
        loop_en = 1'b0;
        wait_done("loop_finish", 20, lp, nv);
        chk("loop_last_pc", 32'(lp), 32'h2);

        // Stall for 4 cycles while word 1 is issued: 7 clocks of 2B002, then 3C003.
        run(6'd3);
        repeat (3) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("stall_instr", 32'(instruction), 32'h2B002);
            chk("stall_pc", 32'(pc), 32'h1);
            @(negedge clk);
            if (i == 3) stall = 1'b0;
        end
        chk("stall_next", 32'(instruction), 32'h3C003);
        wait_done("stall_finish", 10, lp, nv);

        // Stop on the second issue cycle of pc 1, with an attempted write to addr 1.
        run(6'd3);
        repeat (4) @(negedge clk);
        stop = 1'b1; prog_wen = 1'b1; prog_addr = 5'd1; prog_data = 20'hFFFFF;
        @(negedge clk);
        stop = 1'b0; prog_wen = 1'b0;
        chk("stop_valid", 32'(instr_valid), 32'h0);
        chk("stop_instr", 32'(instruction), 32'h0);
        chk("stop_pc", 32'(pc), 32'h0);
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_done", 32'(done), 32'h0);
        run(6'd3);
        repeat (3) @(negedge clk);
        chk("stop_mem_kept", 32'(instruction), 32'h2B002);
        wait_done("stop_rerun_finish", 10, lp, nv);

        // Asynchronous reset between edges mid-issue.
        run(6'd3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_instr", 32'(instruction), 32'h0);
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(6'd3);
        chk("arst_rerun_instr", 32'(instruction), 32'h1A001);
        chk("arst_rerun_pc", 32'(pc), 32'h0);
        wait_done("arst_rerun_finish", 12, lp, nv);

        // Zero-length start is ignored.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        prog_len = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("zero_valid", 32'(instr_valid), 32'h0);

        // Oversized length clamps to the full 32-word memory.
        run(6'd40);
        wait_done("clamp_finish", 200, lp, nv);
        chk("clamp_last_pc", 32'(lp), 32'd31);
        chk("clamp_valid_cycles", 32'(nv), 32'd96);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
